// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// FSM state enumeration and the default datapath width.
package mips_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/mips_muldiv_datapath.sv
// Magnitude registers, radix-2 shift-add / restoring-divide step and the
// final sign fix. The upper half of acc_reg holds product-high or remainder.
module mips_muldiv_datapath
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag_a_reg;
    logic [WIDTH-1:0]   mag_b_reg;
    logic               div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Two's-complement absolute value; 0x80..0 maps onto itself, which is
    // exactly the unsigned magnitude we need.
    assign sign_a = is_signed & op_a[WIDTH-1];
    assign sign_b = is_signed & op_b[WIDTH-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -op_b : op_b;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_reg};
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b_reg});
        div_rem   = div_shift[WIDTH-1:0] - mag_b_reg;
        acc_next  = acc_reg;
        if (div_reg) begin
            if (div_ge)
                acc_next = {div_rem, acc_reg[WIDTH-2:0], 1'b1};
            else
                acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            if (acc_reg[0])
                acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
            else
                acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            mag_a_reg <= '0;
            mag_b_reg <= '0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (load) begin
            acc_reg   <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            mag_a_reg <= mag_a;
            mag_b_reg <= mag_b;
            div_reg   <= is_div;
            neg_q_reg <= sign_a ^ sign_b;
            neg_r_reg <= sign_a;
        end else if (step) begin
            acc_reg   <= acc_next;
        end
    end

    // Divide-by-zero and the signed-overflow case fall out of the plain
    // algorithm plus this sign fix, so no special casing is needed.
    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    assign res_hi = div_reg ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo = div_reg ? quot_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// EX-stage multiply/divide unit: control FSM, iteration counter, HI/LO
// registers and the pipeline stall request.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    md_state_e          state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               is_muldiv;
    logic               is_div;
    logic               is_signed;
    logic               accept;
    logic               dp_load;
    logic               dp_step;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign is_muldiv = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    assign is_div    = (op == MD_DIV)  || (op == MD_DIVU);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    // New work is only taken in IDLE; a cancelled EX instruction never issues.
    assign accept  = (state_reg == S_IDLE) && start && !cancel;
    assign dp_load = accept && is_muldiv;
    assign dp_step = (state_reg == S_RUN) && !cancel;

    mips_muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .is_div    (is_div),
        .is_signed (is_signed),
        .op_a      (rs_val),
        .op_b      (rt_val),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (dp_load) begin
                        state_reg <= S_RUN;
                        cnt_reg   <= CNT_W'(WIDTH);
                        busy      <= 1'b1;
                    end else if (accept && op == MD_MTHI) begin
                        hi <= rs_val;
                    end else if (accept && op == MD_MTLO) begin
                        lo <= rs_val;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1))
                            state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Result commits even if cancel arrives this cycle.
                    hi        <= res_hi;
                    lo        <= res_lo;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign stall_req = busy & (hilo_rd | start) & ~cancel;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: a vector table of mul/div results
// plus hand-written stall, cancel and reset sequences.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    mips_muldiv_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cancel    (cancel),
        .hilo_rd   (hilo_rd),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one mul/div and wait (bounded) for done; returns busy cycle count.
    task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int busy_cnt);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        n = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            n++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", {63'b0, done}, 64'd1);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int bc;
        int errs;
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;

        vecs[0] = '{3'(MD_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'(MD_MULT),  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{3'(MD_DIV),   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'(MD_DIVU),  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4] = '{3'(MD_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{3'(MD_DIVU),  32'd1000,     32'd7,        32'd6,        32'd142};
        vecs[6] = '{3'(MD_DIV),   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'h00000001};
        vecs[7] = '{3'(MD_MULTU), 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[8] = '{3'(MD_DIV),   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{3'(MD_MULT),  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        cancel = 1'b0; hilo_rd = 1'b0;
        #12;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, bc);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, bc);
            check($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].exp_hi});
            check($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].exp_lo});
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d_busy_low", i), {63'b0, busy}, 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_pulse", i), {63'b0, done}, 64'd0);
        end

        // Stall sequence: DIVU 1000/7 with MFHI arriving at T+5.
        @(negedge clk);
        start = 1'b1; op = 3'(MD_DIVU); rs_val = 32'd1000; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        errs = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k == 5) hilo_rd = 1'b1;
            #0;
            if (busy !== 1'b1) errs++;
            if (stall_req !== ((k >= 5) ? 1'b1 : 1'b0)) errs++;
            if (k < 33) @(negedge clk);
        end
        check("stall_while_busy", 64'(errs), 64'd0);
        @(negedge clk);
        check("stall_done", {63'b0, done}, 64'd1);
        check("stall_released", {63'b0, stall_req}, 64'd0);
        check("stall_hi", {32'b0, hi}, 64'd6);
        check("stall_lo", {32'b0, lo}, 64'd142);
        $display("stall seq: hi=%h lo=%h stall_req=%b", hi, lo, stall_req);
        hilo_rd = 1'b0;

        // Start held while busy: MTLO waits, then is accepted when busy falls.
        @(negedge clk);
        start = 1'b1; op = 3'(MD_MULTU); rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        op = 3'(MD_MTLO); rs_val = 32'h0000DEAD;
        errs = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || stall_req !== 1'b1 || lo !== 32'd142) errs++;
            @(negedge clk);
        end
        check("held_start_stall", 64'(errs), 64'd0);
        check("held_start_lo_result", {32'b0, lo}, 64'd15);
        check("held_start_stall_low", {63'b0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("held_start_mtlo", {32'b0, lo}, 64'h0000DEAD);
        check("held_start_hi", {32'b0, hi}, 64'd0);
        $display("held start seq: hi=%h lo=%h", hi, lo);

        // Cancel mid-multiply keeps prior HI/LO and emits no done.
        mt(3'(MD_MTHI), 32'h11111111);
        mt(3'(MD_MTLO), 32'h22222222);
        @(negedge clk);
        start = 1'b1; op = 3'(MD_MULT); rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        #0;
        check("cancel_stall_mask", {63'b0, stall_req}, 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'b0, busy}, 64'd0);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0) errs++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(errs), 64'd0);
        check("cancel_hi", {32'b0, hi}, 64'h11111111);
        check("cancel_lo", {32'b0, lo}, 64'h22222222);
        $display("cancel seq: hi=%h lo=%h", hi, lo);

        // MTLO together with cancel, and a reserved op, both do nothing.
        @(negedge clk);
        start = 1'b1; op = 3'(MD_MTLO); rs_val = 32'h33333333; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0; op = 3'd6; rs_val = 32'h44444444;
        @(negedge clk);
        start = 1'b0;
        check("cancel_mt_lo", {32'b0, lo}, 64'h22222222);
        check("reserved_hi", {32'b0, hi}, 64'h11111111);
        check("reserved_busy", {63'b0, busy}, 64'd0);

        // Cancel during FIX is ignored: result commits.
        @(negedge clk);
        start = 1'b1; op = 3'(MD_MULTU); rs_val = 32'd6; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("fix_cancel_done", {63'b0, done}, 64'd1);
        check("fix_cancel_lo", {32'b0, lo}, 64'd42);
        check("fix_cancel_hi", {32'b0, hi}, 64'd0);
        $display("fix-cancel seq: hi=%h lo=%h done=%b", hi, lo, done);

        // Async reset mid-divide.
        mt(3'(MD_MTHI), 32'h55555555);
        @(negedge clk);
        start = 1'b1; op = 3'(MD_DIV); rs_val = 32'd77; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        hi_prev = hi;
        lo_prev = lo;
        check("pre_rst_busy", {63'b0, busy}, 64'd1);
        check("pre_rst_hi", {32'b0, hi_prev}, 64'h55555555);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_hi", {32'b0, hi}, 64'd0);
        check("async_rst_lo", {32'b0, lo}, 64'd0);
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mt(3'(MD_MTLO), 32'd5);
        check("post_rst_mtlo", {32'b0, lo}, 64'd5);
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("post_rst_no_result", {32'b0, lo}, 64'd5);
        $display("reset seq: prev lo=%h now hi=%h lo=%h", lo_prev, hi, lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
